// File: rtl/anc_sample_sequencer.sv
// Sequencer for the adaptive noise canceller: paces paired I/Q samples, aligns main to noise,
// runs the train/run/freeze schedule and captures results. Build option ANC_SATURATION_MON_EN adds satCount.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for start; no samples accepted, adaptation off
// TRAIN  | adapting; counting issued samples until TRAIN_SAMPLES
// RUN    | adapting; training complete
// FREEZE | samples still flow, adaptation held off while freeze is high
module anc_sample_sequencer #(
  parameter int DATA_BUS_SIZE = 12,
  parameter int MAX_DELAY     = 8,
  parameter int SAMPLE_PERIOD = 2,
  parameter int TRAIN_SAMPLES = 256,
  parameter int ANC_LATENCY   = 2
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             start,
  input  logic                             freeze,
  input  logic [$clog2(MAX_DELAY+1)-1:0]   delaySel,
  input  logic                             inValid,
  output logic                             inReady,
  input  logic [DATA_BUS_SIZE-1:0]         inSignal_I,
  input  logic [DATA_BUS_SIZE-1:0]         inSignal_Q,
  input  logic [DATA_BUS_SIZE-1:0]         inNoise_I,
  input  logic [DATA_BUS_SIZE-1:0]         inNoise_Q,
  output logic                             ancEnable,
  output logic                             ancAdapt,
  output logic [DATA_BUS_SIZE-1:0]         ancSignal_I,
  output logic [DATA_BUS_SIZE-1:0]         ancSignal_Q,
  output logic [DATA_BUS_SIZE-1:0]         ancNoise_I,
  output logic [DATA_BUS_SIZE-1:0]         ancNoise_Q,
  input  logic [DATA_BUS_SIZE-1:0]         ancResult_I,
  input  logic [DATA_BUS_SIZE-1:0]         ancResult_Q,
  output logic                             outValid,
  output logic [DATA_BUS_SIZE-1:0]         outResult_I,
  output logic [DATA_BUS_SIZE-1:0]         outResult_Q,
  output logic [1:0]                       state,
  output logic                             trainDone
`ifdef ANC_SATURATION_MON_EN
  ,
  output logic [15:0]                      satCount
`endif
);

  localparam int SW = $clog2(MAX_DELAY + 1);
  localparam int GW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int TW = $clog2(TRAIN_SAMPLES + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_TRAIN  = 2'd1,
    S_RUN    = 2'd2,
    S_FREEZE = 2'd3
  } state_t;

  state_t                   state_q, state_d;
  logic [GW-1:0]            gap_q, gap_d;
  logic [TW-1:0]            train_cnt_q, train_cnt_d;
  logic                     done_q, done_d;
  logic                     en_q;
  logic [ANC_LATENCY-1:0]   pipe_q, pipe_d;
  logic [ANC_LATENCY:0]     en_taps;
  logic                     capture;
  logic                     accept;
  logic [SW-1:0]            sel_c;

  logic [DATA_BUS_SIZE-1:0] dly_i_q [MAX_DELAY];
  logic [DATA_BUS_SIZE-1:0] dly_q_q [MAX_DELAY];
  logic [DATA_BUS_SIZE-1:0] tap_i, tap_q;
  logic [DATA_BUS_SIZE-1:0] sig_i_q, sig_q_q, noise_i_q, noise_q_q;
  logic [DATA_BUS_SIZE-1:0] res_i_q, res_q_q;

  // Handshake and pacing
  assign inReady = (state_q != S_IDLE) && (gap_q == '0);
  assign accept  = inValid & inReady;

  always_comb begin
    gap_d = gap_q;
    if (accept) begin
      gap_d = GW'(SAMPLE_PERIOD - 1);
    end else if (gap_q != '0) begin
      gap_d = gap_q - GW'(1);
    end
  end

  // Alignment tap select; taps hold past accepted samples, newest first
  always_comb begin
    sel_c = delaySel;
    if (delaySel > SW'(MAX_DELAY)) begin
      sel_c = SW'(MAX_DELAY);
    end
  end

  always_comb begin
    tap_i = inSignal_I;
    tap_q = inSignal_Q;
    for (int k = 1; k <= MAX_DELAY; k++) begin
      if (sel_c == SW'(k)) begin
        tap_i = dly_i_q[k-1];
        tap_q = dly_q_q[k-1];
      end
    end
  end

  // Result pipeline: en_taps[0] is the live strobe, en_taps[k] the strobe k cycles ago
  assign en_taps = {pipe_q, en_q};
  assign pipe_d  = en_taps[ANC_LATENCY-1:0];
  assign capture = en_taps[ANC_LATENCY-1];

  // Schedule FSM
  always_comb begin
    state_d     = state_q;
    train_cnt_d = train_cnt_q;
    done_d      = done_q;
    if (start) begin
      state_d     = S_TRAIN;
      train_cnt_d = '0;
      done_d      = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_IDLE;
        end
        S_TRAIN: begin
          if (en_q) begin
            train_cnt_d = train_cnt_q + TW'(1);
            if (train_cnt_q == TW'(TRAIN_SAMPLES - 1)) begin
              state_d = S_RUN;
              done_d  = 1'b1;
            end
          end
        end
        S_RUN: begin
          if (freeze) state_d = S_FREEZE;
        end
        S_FREEZE: begin
          if (!freeze) state_d = S_RUN;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    ancAdapt = 1'b0;
    if ((state_q == S_TRAIN) || (state_q == S_RUN)) begin
      ancAdapt = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      gap_q       <= '0;
      train_cnt_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      gap_q       <= gap_d;
      train_cnt_q <= train_cnt_d;
      done_q      <= done_d;
    end
  end

  // A sample accepted in the same cycle as start is consumed but dropped
  always_ff @(posedge clock) begin
    if (reset) begin
      en_q      <= 1'b0;
      pipe_q    <= '0;
      sig_i_q   <= '0;
      sig_q_q   <= '0;
      noise_i_q <= '0;
      noise_q_q <= '0;
      res_i_q   <= '0;
      res_q_q   <= '0;
      for (int k = 0; k < MAX_DELAY; k++) begin
        dly_i_q[k] <= '0;
        dly_q_q[k] <= '0;
      end
    end else if (start) begin
      en_q   <= 1'b0;
      pipe_q <= '0;
      for (int k = 0; k < MAX_DELAY; k++) begin
        dly_i_q[k] <= '0;
        dly_q_q[k] <= '0;
      end
    end else begin
      en_q   <= accept;
      pipe_q <= pipe_d;
      if (accept) begin
        sig_i_q    <= tap_i;
        sig_q_q    <= tap_q;
        noise_i_q  <= inNoise_I;
        noise_q_q  <= inNoise_Q;
        dly_i_q[0] <= inSignal_I;
        dly_q_q[0] <= inSignal_Q;
        for (int k = 1; k < MAX_DELAY; k++) begin
          dly_i_q[k] <= dly_i_q[k-1];
          dly_q_q[k] <= dly_q_q[k-1];
        end
      end
      if (capture) begin
        res_i_q <= ancResult_I;
        res_q_q <= ancResult_Q;
      end
    end
  end

`ifdef ANC_SATURATION_MON_EN
  localparam logic [DATA_BUS_SIZE-1:0] SMAX = {1'b0, {(DATA_BUS_SIZE-1){1'b1}}};
  localparam logic [DATA_BUS_SIZE-1:0] SMIN = {1'b1, {(DATA_BUS_SIZE-1){1'b0}}};

  logic [15:0] sat_q;
  logic        sat_hit;

  assign sat_hit = outValid && ((res_i_q == SMAX) || (res_i_q == SMIN) ||
                                (res_q_q == SMAX) || (res_q_q == SMIN));

  always_ff @(posedge clock) begin
    if (reset || start) begin
      sat_q <= '0;
    end else if (sat_hit && (sat_q != 16'hFFFF)) begin
      sat_q <= sat_q + 16'd1;
    end
  end

  assign satCount = sat_q;
`endif

  assign ancEnable   = en_q;
  assign ancSignal_I = sig_i_q;
  assign ancSignal_Q = sig_q_q;
  assign ancNoise_I  = noise_i_q;
  assign ancNoise_Q  = noise_q_q;
  assign outValid    = pipe_q[ANC_LATENCY-1];
  assign outResult_I = res_i_q;
  assign outResult_Q = res_q_q;
  assign state       = state_q;
  assign trainDone   = done_q;

endmodule

// File: tb/tb_anc_sample_sequencer.sv
// Bench for anc_sample_sequencer: directed literal checks plus randomized traffic against a queue-based model.
`timescale 1ns/1ps
module tb_anc_sample_sequencer;
  localparam int W    = 12;
  localparam int MD   = 8;
  localparam int SP   = 2;
  localparam int TS   = 4;
  localparam int L    = 2;
  localparam int SW   = $clog2(MD + 1);
  localparam int NLOG = 8192;

  logic clock = 1'b0;
  logic reset, start, freeze, inValid, inReady;
  logic [SW-1:0] delaySel;
  logic [W-1:0] inSignal_I, inSignal_Q, inNoise_I, inNoise_Q;
  logic ancEnable, ancAdapt;
  logic [W-1:0] ancSignal_I, ancSignal_Q, ancNoise_I, ancNoise_Q;
  logic [W-1:0] ancResult_I, ancResult_Q, outResult_I, outResult_Q;
  logic outValid, trainDone;
  logic [1:0] state;
`ifdef ANC_SATURATION_MON_EN
  logic [15:0] satCount;
`endif

  always #5 clock = ~clock;

  anc_sample_sequencer #(
    .DATA_BUS_SIZE(W), .MAX_DELAY(MD), .SAMPLE_PERIOD(SP),
    .TRAIN_SAMPLES(TS), .ANC_LATENCY(L)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .freeze(freeze),
    .delaySel(delaySel), .inValid(inValid), .inReady(inReady),
    .inSignal_I(inSignal_I), .inSignal_Q(inSignal_Q),
    .inNoise_I(inNoise_I), .inNoise_Q(inNoise_Q),
    .ancEnable(ancEnable), .ancAdapt(ancAdapt),
    .ancSignal_I(ancSignal_I), .ancSignal_Q(ancSignal_Q),
    .ancNoise_I(ancNoise_I), .ancNoise_Q(ancNoise_Q),
    .ancResult_I(ancResult_I), .ancResult_Q(ancResult_Q),
    .outValid(outValid), .outResult_I(outResult_I), .outResult_Q(outResult_Q),
    .state(state), .trainDone(trainDone)
`ifdef ANC_SATURATION_MON_EN
    , .satCount(satCount)
`endif
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // stimulus for the next cycle
  bit d_reset, d_start, d_freeze, d_valid;
  logic [SW-1:0] d_sel;
  logic [W-1:0] d_si, d_sq, d_ni, d_nq, d_ri, d_rq;

  // behavioural model
  bit mv = 0;
  int m_state, m_strobes, m_last_acc, m_sat;
  bit m_done, m_acc, e_en, e_ov;
  logic [W-1:0] e_si, e_sq, e_ni, e_nq, e_ri, e_rq;
  logic [W-1:0] hist_i[$], hist_q[$];
  int pend[$];

  // per-cycle log of DUT outputs for directed literal checks
  bit lg_ready[NLOG], lg_en[NLOG], lg_ov[NLOG], lg_done[NLOG], lg_adapt[NLOG];
  int lg_state[NLOG];
  logic [W-1:0] lg_si[NLOG], lg_ni[NLOG], lg_ri[NLOG];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

`ifdef ANC_SATURATION_MON_EN
  function automatic bit is_sat(input logic [W-1:0] v);
    return (v == 12'h7FF) || (v == 12'h800);
  endfunction
`endif

  task automatic model_reset();
    m_state = 0; m_done = 0; m_strobes = 0; m_last_acc = -1000; m_sat = 0; m_acc = 0;
    e_en = 0; e_ov = 0;
    e_si = '0; e_sq = '0; e_ni = '0; e_nq = '0; e_ri = '0; e_rq = '0;
    hist_i.delete(); hist_q.delete(); pend.delete();
    mv = 1;
  endtask

  task automatic step();
    bit ready, acc, nxt_en, nxt_ov;
    int sel;
    @(negedge clock);
    if (cyc < NLOG) begin
      lg_ready[cyc] = inReady; lg_en[cyc] = ancEnable; lg_ov[cyc] = outValid;
      lg_done[cyc] = trainDone; lg_adapt[cyc] = ancAdapt; lg_state[cyc] = int'(state);
      lg_si[cyc] = ancSignal_I; lg_ni[cyc] = ancNoise_I; lg_ri[cyc] = outResult_I;
    end
    if (mv) begin
      ready = (m_state != 0) && (cyc - m_last_acc >= SP);
      chk("state", state, m_state);
      chk("inReady", inReady, ready);
      chk("ancAdapt", ancAdapt, (m_state == 1 || m_state == 2));
      chk("ancEnable", ancEnable, e_en);
      chk("trainDone", trainDone, m_done);
      chk("outValid", outValid, e_ov);
      chk("outResult_I", outResult_I, e_ri);
      chk("outResult_Q", outResult_Q, e_rq);
      if (e_en) begin
        chk("ancSignal_I", ancSignal_I, e_si);
        chk("ancSignal_Q", ancSignal_Q, e_sq);
        chk("ancNoise_I", ancNoise_I, e_ni);
        chk("ancNoise_Q", ancNoise_Q, e_nq);
      end
`ifdef ANC_SATURATION_MON_EN
      chk("satCount", satCount, m_sat);
`endif
    end
    reset = d_reset; start = d_start; freeze = d_freeze;
    inValid = d_valid & ~d_start; delaySel = d_sel;
    inSignal_I = d_si; inSignal_Q = d_sq; inNoise_I = d_ni; inNoise_Q = d_nq;
    ancResult_I = d_ri; ancResult_Q = d_rq;
    if (d_reset) begin
      model_reset();
    end else begin
      ready = (m_state != 0) && (cyc - m_last_acc >= SP);
      acc = inValid && ready;
      m_acc = acc;
      if (acc) m_last_acc = cyc;
      nxt_en = 0; nxt_ov = 0;
      if (e_en) pend.push_back(cyc);
`ifdef ANC_SATURATION_MON_EN
      if (d_start) m_sat = 0;
      else if (e_ov && (is_sat(e_ri) || is_sat(e_rq)) && m_sat < 65535) m_sat++;
`endif
      if (d_start) begin
        pend.delete(); hist_i.delete(); hist_q.delete();
        m_strobes = 0; m_done = 0; m_state = 1;
      end else begin
        if (pend.size() > 0 && pend[0] + L - 1 == cyc) begin
          nxt_ov = 1; e_ri = ancResult_I; e_rq = ancResult_Q;
          void'(pend.pop_front());
        end
        if (acc) begin
          hist_i.push_front(inSignal_I);
          hist_q.push_front(inSignal_Q);
          sel = (int'(delaySel) > MD) ? MD : int'(delaySel);
          e_si = (sel < hist_i.size()) ? hist_i[sel] : '0;
          e_sq = (sel < hist_q.size()) ? hist_q[sel] : '0;
          e_ni = inNoise_I; e_nq = inNoise_Q;
          nxt_en = 1;
          if (hist_i.size() > MD + 1) begin
            void'(hist_i.pop_back());
            void'(hist_q.pop_back());
          end
        end
        case (m_state)
          1: if (e_en) begin
               m_strobes++;
               if (m_strobes == TS) begin m_state = 2; m_done = 1; end
             end
          2: if (freeze) m_state = 3;
          3: if (!freeze) m_state = 2;
          default: ;
        endcase
      end
      e_en = nxt_en; e_ov = nxt_ov;
    end
    cyc++;
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, fs, fr, st, n, cnt;
    bit found;
    d_reset = 1; d_start = 0; d_freeze = 0; d_valid = 0; d_sel = '0;
    d_si = '0; d_sq = '0; d_ni = '0; d_nq = '0; d_ri = '0; d_rq = '0;
    reset = 1; start = 0; freeze = 0; inValid = 0; delaySel = '0;
    inSignal_I = '0; inSignal_Q = '0; inNoise_I = '0; inNoise_Q = '0;
    ancResult_I = '0; ancResult_Q = '0;
    repeat (3) step();
    d_reset = 0;
    step();
    chk("rst_state", state, 0);
    chk("rst_inReady", inReady, 0);
    chk("rst_outValid", outValid, 0);
    chk("rst_outResult_I", outResult_I, 0);
    chk("rst_ancSignal_I", ancSignal_I, 0);
    chk("rst_trainDone", trainDone, 0);
    step();

    // pacing, training, alignment and capture latency
    d_sel = 3; d_ri = 12'h0AA; d_rq = 12'h011;
    s = cyc; d_start = 1; step(); d_start = 0;
    d_valid = 1; n = 0;
    for (int i = 0; i < 12; i++) begin
      d_si = W'(n + 1); d_ni = W'(101 + n); d_sq = W'($urandom); d_nq = W'($urandom);
      d_ri = (cyc == s + 3) ? 12'h155 : 12'h0AA;
      step();
      if (m_acc) n++;
    end
    chk("t1_ready_a", lg_ready[s+1], 1);
    chk("t1_ready_b", lg_ready[s+2], 0);
    chk("t1_ready_c", lg_ready[s+3], 1);
    chk("t1_ready_d", lg_ready[s+4], 0);
    chk("t1_en_first", lg_en[s+2], 1);
    chk("t1_en_gap", lg_en[s+3], 0);
    chk("t3_sig1", lg_si[s+2], 0);
    chk("t3_sig3", lg_si[s+6], 0);
    chk("t3_sig4", lg_si[s+8], 1);
    chk("t3_sig5", lg_si[s+10], 2);
    chk("t3_noise1", lg_ni[s+2], 101);
    chk("t3_noise4", lg_ni[s+8], 104);
    chk("t2_state_train", lg_state[s+8], 1);
    chk("t2_state_run", lg_state[s+9], 2);
    chk("t2_trainDone", lg_done[s+9], 1);
    chk("t2_adapt", lg_adapt[s+9], 1);
    chk("t4_no_early_ov", lg_ov[s+3], 0);
    chk("t4_ov", lg_ov[s+4], 1);
    chk("t4_result", lg_ri[s+4], 12'h155);
    chk("t4_hold", lg_ri[s+5], 12'h155);

    // freeze in RUN
    d_freeze = 1; fs = cyc;
    repeat (10) begin d_si = W'($urandom); d_ni = W'($urandom); step(); end
    d_freeze = 0; fr = cyc;
    repeat (4) step();
    cnt = 0;
    for (int c = fs + 1; c <= fs + 10; c++) cnt += int'(lg_en[c]);
    chk("t5_state_freeze", lg_state[fs+1], 3);
    chk("t5_adapt_off", lg_adapt[fs+1], 0);
    chk("t5_strobes", cnt, 5);
    chk("t5_state_run", lg_state[fr+1], 2);
    chk("t5_adapt_on", lg_adapt[fr+1], 1);

    // restart with a result in flight
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (e_en) found = 1;
      else step();
    end
    chk("t6_sync", found, 1);
    st = cyc; d_start = 1; step(); d_start = 0;
    repeat (6) step();
    chk("t6_dropped_ov", lg_ov[st+2], 0);
    chk("t6_state", lg_state[st+1], 1);
    chk("t6_trainDone", lg_done[st+1], 0);
    chk("t6_en", lg_en[st+2], 1);
    chk("t6_tap_zero", lg_si[st+2], 0);

    // randomized traffic
    for (int i = 0; i < 2500; i++) begin
      d_reset = (i == 1200 || i == 1201);
      d_start = ($urandom_range(0, 149) == 0);
      d_valid = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 19) == 0) d_freeze = ~d_freeze;
      if ($urandom_range(0, 29) == 0) d_sel = SW'($urandom_range(0, 15));
      d_si = W'($urandom); d_sq = W'($urandom); d_ni = W'($urandom); d_nq = W'($urandom);
      case ($urandom_range(0, 3))
        0: d_ri = 12'h7FF;
        1: d_ri = 12'h800;
        default: d_ri = W'($urandom);
      endcase
      d_rq = ($urandom_range(0, 7) == 0) ? 12'h800 : W'($urandom);
      if (i == 1210) d_start = 1;
      step();
    end
    d_reset = 0; d_start = 0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
